// File: rtl/mem_block_responder.sv
// mem_block_responder: memory-side responder for the 128-bit cache block
// interface. Accepts held read/write requests, services them from an internal
// block array after LATENCY cycles and returns a one-cycle mem_ready strobe.
module mem_block_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_addr,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_ready,
    output logic         busy,
    output logic         err
);

    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [7:0]            cnt;
    logic [DEPTH_LOG2-1:0] idx;
    logic [127:0]          wdata_q;
    logic                  is_write;
    logic [127:0]          blocks [0:(1 << DEPTH_LOG2) - 1];

    logic req;
    logic req_held;
    logic accept;
    logic fire;
    logic abort;
    logic ready_d;
    logic busy_d;
    logic unused_addr_hi;

    assign req            = mem_read | mem_write;
    // A dual request is treated as a write, so the write line is the one that must stay held.
    assign req_held       = is_write ? mem_write : mem_read;
    // Upper address bits alias onto the array and are deliberately dropped.
    assign unused_addr_hi = ^mem_addr[27:DEPTH_LOG2];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Every request, including LATENCY=1, passes through BUSY
    // so that the access lands exactly LATENCY edges after acceptance; the access
    // fires on the BUSY edge that sees the counter already at zero.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (req) state_next = BUSY;
            BUSY: begin
                if (!req_held)       state_next = IDLE;
                else if (cnt == '0)  state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Decode of per-cycle actions and next values of the registered outputs.
    always_comb begin
        accept  = (state == IDLE) && req;
        fire    = (state == BUSY) && req_held && (cnt == '0);
        abort   = (state == BUSY) && !req_held;
        ready_d = (state_next == RESP);
        busy_d  = (state_next != IDLE);
    end

    // Request latch, latency counter, read data and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            idx       <= '0;
            wdata_q   <= '0;
            is_write  <= 1'b0;
            mem_rdata <= '0;
            mem_ready <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_ready <= ready_d;
            busy      <= busy_d;
            if (accept) begin
                idx      <= mem_addr[DEPTH_LOG2-1:0];
                wdata_q  <= mem_wdata;
                is_write <= mem_write;
                cnt      <= CNT_LOAD;
                if (mem_read && mem_write) err <= 1'b1;
            end else if ((state == BUSY) && (cnt != '0)) begin
                cnt <= cnt - 8'd1;
            end
            if (abort) err <= 1'b1;
            if (fire && !is_write) mem_rdata <= blocks[idx];
        end
    end

    // Block array write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (fire && is_write) blocks[idx] <= wdata_q;
    end

endmodule
